// File: rtl/ofdm_frame_parse_pkg.sv
// Shared definitions for the OFDM receive deframer: state codes, FCH layout, FCH field struct.
package ofdm_frame_parse_pkg;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StFch  = 4'd1,
    StData = 4'd2,
    StDone = 4'd3
  } state_e;

  // The FCH occupies the first three bytes of the BPSK symbol; anything after is zero padding.
  localparam int unsigned FchLen = 3;

  // Single-bit field positions inside the FCH bytes.
  localparam int unsigned FchB0Rep0Bit = 7;
  localparam int unsigned FchB0RsvdBit = 6;
  localparam int unsigned FchB1Rep1Bit = 0;

  typedef struct packed {
    logic [7:0] size;
    logic [2:0] coding;
    logic [1:0] rep;
    logic [5:0] bitmap;
  } fch_t;

endpackage

// File: rtl/ofdm_fch_decode.sv
// Combinational FCH decoder: splits b0..b2 into fields and flags reserved-bit violations.
module ofdm_fch_decode
  import ofdm_frame_parse_pkg::*;
(
  input  logic [7:0] i_b0,
  input  logic [7:0] i_b1,
  input  logic [7:0] i_b2,
  output fch_t       o_fch,
  output logic       o_ok
);

  assign o_fch.bitmap = i_b0[5:0];
  assign o_fch.rep    = {i_b1[FchB1Rep1Bit], i_b0[FchB0Rep0Bit]};
  assign o_fch.coding = i_b1[3:1];
  assign o_fch.size   = {i_b2[3:0], i_b1[7:4]};

  // Reserved bits: b0[6] and the upper nibble of b2 must be zero.
  assign o_ok = ~i_b0[FchB0RsvdBit] & (i_b2[7:4] == 4'h0);

endmodule

// File: rtl/ofdm_frame_parse.sv
// Receive deframer: parses the FCH symbol, then forwards fch_frame_size data symbols of payload.
module ofdm_frame_parse
  import ofdm_frame_parse_pkg::*;
#(
  parameter int unsigned MAX_SYMBOL_BYTES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       frame_start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       fch_valid,
  output logic [7:0] fch_frame_size,
  output logic [2:0] fch_coding,
  output logic [1:0] fch_rep,
  output logic [5:0] fch_bitmap,
  output logic       done_receive,
  output logic       frame_error,
  output logic [3:0] o_state,
  output logic [7:0] o_symbol_count
);

  localparam int unsigned IdxW = $clog2(MAX_SYMBOL_BYTES) + 1;
  localparam logic [IdxW-1:0] MaxIdx     = IdxW'(MAX_SYMBOL_BYTES);
  localparam logic [IdxW-1:0] IdxB0      = IdxW'(0);
  localparam logic [IdxW-1:0] IdxB1      = IdxW'(1);
  localparam logic [IdxW-1:0] IdxLastHdr = IdxW'(FchLen - 1);

  state_e          r_state, w_state_next;
  logic [IdxW-1:0] r_idx, w_idx_next, w_idx_cur;
  logic [7:0]      r_b0, r_b1, r_b2, w_b0_next, w_b1_next, w_b2_next;
  fch_t            r_fch, w_fch_next, w_dec_fch;
  logic            r_fch_valid, w_fch_valid_next;
  logic [7:0]      r_count, w_count_next;
  logic            r_out_valid, w_out_valid_next;
  logic [7:0]      r_out_data, w_out_data_next;
  logic            r_out_last, w_out_last_next;
  logic            r_err, w_err_next;
  logic            w_in_fch, w_in_data, w_bad, w_dec_ok;
  logic [7:0]      w_dec_b2;

  // When the current byte is b2 the decoder must see it before it is registered.
  assign w_dec_b2 = (w_idx_cur == IdxLastHdr) ? in_data : r_b2;

  ofdm_fch_decode u_fch_decode (
    .i_b0  (r_b0),
    .i_b1  (r_b1),
    .i_b2  (w_dec_b2),
    .o_fch (w_dec_fch),
    .o_ok  (w_dec_ok)
  );

  // Next-state, byte parsing and registered-output computation.
  always_comb begin
    w_state_next     = r_state;
    w_b0_next        = r_b0;
    w_b1_next        = r_b1;
    w_b2_next        = r_b2;
    w_fch_next       = r_fch;
    w_fch_valid_next = r_fch_valid;
    w_count_next     = r_count;
    w_out_valid_next = 1'b0;
    w_out_data_next  = r_out_data;
    w_out_last_next  = 1'b0;
    w_err_next       = 1'b0;
    w_idx_cur        = r_idx;
    w_in_fch         = 1'b0;
    w_in_data        = 1'b0;
    w_bad            = 1'b0;

    // frame_start always re-arms; the same-cycle byte becomes b0 of the new FCH.
    if (frame_start) begin
      w_err_next       = (r_state == StFch) || (r_state == StData);
      w_fch_valid_next = 1'b0;
      w_count_next     = 8'd0;
      w_idx_cur        = IdxB0;
      w_state_next     = StFch;
      w_in_fch         = 1'b1;
    end else begin
      unique case (r_state)
        StIdle:  ;
        StFch:   w_in_fch = 1'b1;
        StData:  w_in_data = 1'b1;
        StDone:  w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end

    w_idx_next = w_idx_cur;

    if (w_in_fch && in_valid) begin
      if (w_idx_cur >= MaxIdx) begin
        w_bad = 1'b1;
      end else if (w_idx_cur == IdxB0) begin
        w_b0_next = in_data;
        w_bad     = in_data[FchB0RsvdBit];
      end else if (w_idx_cur == IdxB1) begin
        w_b1_next = in_data;
      end else if (w_idx_cur == IdxLastHdr) begin
        w_b2_next = in_data;
        w_bad     = ~w_dec_ok;
      end else begin
        w_bad = (in_data != 8'h00);
      end
      if (in_last && (w_idx_cur < IdxLastHdr)) w_bad = 1'b1;

      if (w_bad) begin
        w_err_next   = 1'b1;
        w_state_next = StIdle;
        w_idx_next   = IdxB0;
      end else if (in_last) begin
        w_fch_next       = w_dec_fch;
        w_fch_valid_next = 1'b1;
        w_idx_next       = IdxB0;
        w_state_next     = (w_dec_fch.size == 8'd0) ? StDone : StData;
      end else begin
        w_idx_next = w_idx_cur + IdxW'(1);
      end
    end

    if (w_in_data && in_valid) begin
      if (r_idx >= MaxIdx) begin
        w_err_next   = 1'b1;
        w_state_next = StIdle;
        w_idx_next   = IdxB0;
      end else begin
        w_out_valid_next = 1'b1;
        w_out_data_next  = in_data;
        w_out_last_next  = in_last;
        if (in_last) begin
          w_idx_next   = IdxB0;
          w_count_next = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
          if (({1'b0, r_count} + 9'd1) == {1'b0, r_fch.size}) w_state_next = StDone;
        end else begin
          w_idx_next = r_idx + IdxW'(1);
        end
      end
    end
  end

  // State and output registers; synchronous active-low reset, en low freezes everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_b0        <= 8'h00;
      r_b1        <= 8'h00;
      r_b2        <= 8'h00;
      r_fch       <= '0;
      r_fch_valid <= 1'b0;
      r_count     <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else if (en) begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_b0        <= w_b0_next;
      r_b1        <= w_b1_next;
      r_b2        <= w_b2_next;
      r_fch       <= w_fch_next;
      r_fch_valid <= w_fch_valid_next;
      r_count     <= w_count_next;
      r_out_valid <= w_out_valid_next;
      r_out_data  <= w_out_data_next;
      r_out_last  <= w_out_last_next;
      r_err       <= w_err_next;
    end
  end

  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_last       = r_out_last;
  assign fch_valid      = r_fch_valid;
  assign fch_frame_size = r_fch.size;
  assign fch_coding     = r_fch.coding;
  assign fch_rep        = r_fch.rep;
  assign fch_bitmap     = r_fch.bitmap;
  assign done_receive   = (r_state == StDone);
  assign frame_error    = r_err;
  assign o_state        = r_state;
  assign o_symbol_count = r_count;

endmodule

// File: tb/tb_ofdm_frame_parse.sv
// Directed self-checking bench for ofdm_frame_parse.
module tb_ofdm_frame_parse;

  logic       clk = 1'b0;
  logic       reset, en, frame_start, in_valid, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_last, fch_valid, done_receive, frame_error;
  logic [7:0] out_data, fch_frame_size, o_symbol_count;
  logic [2:0] fch_coding;
  logic [1:0] fch_rep;
  logic [5:0] fch_bitmap;
  logic [3:0] o_state;

  int checks = 0;
  int failures = 0;
  int n_ov, n_ol, n_done, n_err;
  int unsigned hash_obs, hash_exp;

  ofdm_frame_parse #(.MAX_SYMBOL_BYTES(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .frame_start    (frame_start),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .fch_valid      (fch_valid),
    .fch_frame_size (fch_frame_size),
    .fch_coding     (fch_coding),
    .fch_rep        (fch_rep),
    .fch_bitmap     (fch_bitmap),
    .done_receive   (done_receive),
    .frame_error    (frame_error),
    .o_state        (o_state),
    .o_symbol_count (o_symbol_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, step past the edge, tally outputs produced by an enabled edge.
  task automatic cyc(input logic fs, input logic v, input logic [7:0] d, input logic l);
    frame_start = fs;
    in_valid    = v;
    in_data     = d;
    in_last     = l;
    @(posedge clk);
    #1;
    if (en && reset) begin
      if (out_valid) begin
        n_ov++;
        hash_obs = hash_obs * 31 + out_data;
      end
      if (out_last) n_ol++;
      if (done_receive) n_done++;
      if (frame_error) n_err++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic clr();
    n_ov = 0; n_ol = 0; n_done = 0; n_err = 0;
    hash_obs = 0; hash_exp = 0;
  endtask

  task automatic send_fch(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    cyc(1'b0, 1'b1, b0, 1'b0);
    cyc(1'b0, 1'b1, b1, 1'b0);
    cyc(1'b0, 1'b1, b2, 1'b1);
  endtask

  // Payload bytes base, base+1, ...; expected hash follows the bytes that must be forwarded.
  task automatic send_data(input int n, input logic [7:0] base, input logic last);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + 8'(i);
      hash_exp = hash_exp * 31 + d;
      cyc(1'b0, 1'b1, d, last && (i == n - 1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, o_state, 4'd0);
    check({tag, "_fchv"}, fch_valid, 1'b0);
    check({tag, "_fields"}, {fch_frame_size, fch_coding, fch_rep, fch_bitmap}, 19'd0);
    check({tag, "_out"}, {out_valid, out_data, out_last}, 10'd0);
    check({tag, "_pulses"}, {done_receive, frame_error}, 2'd0);
    check({tag, "_count"}, o_symbol_count, 8'd0);
  endtask

  initial begin
    reset = 1'b0; en = 1'b1;
    frame_start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    clr();
    idle(2);
    check_all_zero("rst");
    reset = 1'b1;
    idle(1);

    // Size-3 frame, 64-byte FCH symbol, three 64-byte data symbols.
    clr();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("t1_arm", o_state, 4'd1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h30, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    check("t1_fchv", fch_valid, 1'b1);
    check("t1_size", fch_frame_size, 8'd3);
    check("t1_state", o_state, 4'd2);
    send_data(1, 8'h10, 1'b0);
    check("t1_lat", {out_valid, out_data}, {1'b1, 8'h10});
    send_data(63, 8'h11, 1'b1);
    check("t1_cnt1", o_symbol_count, 8'd1);
    send_data(64, 8'h40, 1'b1);
    send_data(64, 8'h80, 1'b1);
    check("t1_done", {done_receive, out_last, o_state}, {1'b1, 1'b1, 4'd3});
    check("t1_cnt3", o_symbol_count, 8'd3);
    idle(1);
    check("t1_idle", {done_receive, o_state}, {1'b0, 4'd0});
    check("t1_nov", n_ov, 192);
    check("t1_nol", n_ol, 3);
    check("t1_ndone", n_done, 1);
    check("t1_nerr", n_err, 0);
    check("t1_hash", hash_obs, hash_exp);

    // Size-0 FCH with non-zero coding/rep/bitmap: DONE right after the FCH.
    clr();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    send_fch(8'hAA, 8'h0B, 8'h00);
    check("t2_done", {o_state, done_receive, fch_valid}, {4'd3, 1'b1, 1'b1});
    check("t2_fields", {fch_frame_size, fch_coding, fch_rep, fch_bitmap},
          {8'd0, 3'd5, 2'd3, 6'h2A});
    idle(1);
    check("t2_idle", {o_state, fch_valid}, {4'd0, 1'b1});
    check("t2_nov", n_ov, 0);

    // Reserved bit set in b0: immediate error, the rest of the frame is dropped.
    clr();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("t3_clr", fch_valid, 1'b0);
    cyc(1'b0, 1'b1, 8'h40, 1'b0);
    check("t3_err", {frame_error, o_state, fch_valid}, {1'b1, 4'd0, 1'b0});
    cyc(1'b0, 1'b1, 8'h30, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h55, i == 3);
    check("t3_drop", {n_ov, n_err}, {32'd0, 32'd1});
    check("t3_state", o_state, 4'd0);

    // Restart mid-DATA with b0 on the frame_start cycle.
    clr();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    send_fch(8'h00, 8'h30, 8'h00);
    send_data(4, 8'h20, 1'b1);
    check("t4_cnt1", o_symbol_count, 8'd1);
    cyc(1'b1, 1'b1, 8'h00, 1'b0);
    check("t4_err", {frame_error, o_state, fch_valid}, {1'b1, 4'd1, 1'b0});
    check("t4_cnt0", o_symbol_count, 8'd0);
    cyc(1'b0, 1'b1, 8'h20, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    check("t4_fch", {fch_valid, fch_frame_size, o_state}, {1'b1, 8'd2, 4'd2});
    send_data(4, 8'h30, 1'b1);
    send_data(4, 8'h40, 1'b1);
    check("t4_done", {done_receive, o_symbol_count}, {1'b1, 8'd2});
    idle(1);
    check("t4_counts", {n_ov[7:0], n_done[7:0], n_err[7:0]}, {8'd12, 8'd1, 8'd1});
    check("t4_hash", hash_obs, hash_exp);

    // en low for 5 cycles mid-symbol with garbage inputs: no visible effect.
    clr();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    send_fch(8'h00, 8'h20, 8'h00);
    send_data(3, 8'h50, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 8'hFF, 1'b1);
    check("t5_frz", {o_state, o_symbol_count, out_valid, out_data}, {4'd2, 8'd0, 1'b1, 8'h52});
    en = 1'b1;
    send_data(5, 8'h53, 1'b1);
    send_data(8, 8'h60, 1'b1);
    check("t5_done", {done_receive, o_symbol_count}, {1'b1, 8'd2});
    idle(1);
    check("t5_counts", {n_ov[7:0], n_ol[7:0], n_done[7:0], n_err[7:0]},
          {8'd16, 8'd2, 8'd1, 8'd0});
    check("t5_hash", hash_obs, hash_exp);

    // Overlong data symbol: the 65th byte errors out, no done.
    clr();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    send_fch(8'h00, 8'h10, 8'h00);
    send_data(64, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'hAA, 1'b0);
    check("t6_err", {frame_error, o_state, out_valid}, {1'b1, 4'd0, 1'b0});
    idle(1);
    check("t6_counts", {n_ov[7:0], n_done[7:0], n_err[7:0]}, {8'd64, 8'd0, 8'd1});
    check("t6_hash", hash_obs, hash_exp);

    // Reset mid-DATA.
    clr();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    send_fch(8'h00, 8'h30, 8'h00);
    send_data(5, 8'h00, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 1'b1, 8'h77, 1'b0);
    check_all_zero("t7");
    reset = 1'b1;
    idle(1);
    check("t7_idle", o_state, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
